// File: rtl/raster_ctrl_pkg.sv
// Shared types and widths for the edge-rasterizer control slice.
package raster_ctrl_pkg;

  localparam int COORD_W = 16;
  localparam int DEPTH_W = 2;
  localparam int COLOR_W = 16;
  localparam int PIXEL_W = 2 * COORD_W + DEPTH_W + COLOR_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_BOUND  = 3'd2,
    ST_EDGES  = 3'd3,
    ST_SETUP  = 3'd4,
    ST_RASTER = 3'd5,
    ST_DRAIN  = 3'd6
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DEPTH_W-1:0] depth;
    logic [COLOR_W-1:0] color;
  } pixel_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous pixel FIFO; registered storage, no fall-through, synchronous flush.
module pixel_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int PIXEL_W    = 50
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [PIXEL_W-1:0]          din,
  output logic [PIXEL_W-1:0]          dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [PIXEL_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees the slot this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/raster_sequencer.sv
// Drives the edge rasterizer through load/bound/edges/setup/loop for one triangle
// at a time and buffers its pixels onto a valid/ready stream.
module raster_sequencer
  import raster_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tri_valid,
  output logic             tri_ready,
  input  logic [15:0]      tri_v0_x,
  input  logic [15:0]      tri_v0_y,
  input  logic [15:0]      tri_v1_x,
  input  logic [15:0]      tri_v1_y,
  input  logic [15:0]      tri_v2_x,
  input  logic [15:0]      tri_v2_y,
  input  logic [1:0]       tri_v0_depth,
  input  logic [1:0]       tri_v1_depth,
  input  logic [1:0]       tri_v2_depth,
  input  logic [15:0]      tri_color,
  input  logic             abort,
  output logic             ras_start_new_triangle,
  output logic             ras_get_boundary_coords,
  output logic             ras_form_edges,
  output logic             ras_pixel_loop_setup,
  output logic             ras_rasterize_pixels,
  output logic [15:0]      ras_v0_x,
  output logic [15:0]      ras_v0_y,
  output logic [15:0]      ras_v1_x,
  output logic [15:0]      ras_v1_y,
  output logic [15:0]      ras_v2_x,
  output logic [15:0]      ras_v2_y,
  output logic [1:0]       ras_v0_depth,
  output logic [1:0]       ras_v1_depth,
  output logic [1:0]       ras_v2_depth,
  output logic [15:0]      ras_color,
  input  logic             ras_write_pixel,
  input  logic             ras_done,
  input  logic [15:0]      ras_pixel_x,
  input  logic [15:0]      ras_pixel_y,
  input  logic [1:0]       ras_pixel_depth,
  input  logic [15:0]      ras_pixel_color,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [15:0]      pix_x,
  output logic [15:0]      pix_y,
  output logic [1:0]       pix_depth,
  output logic [15:0]      pix_color,
  output logic             busy,
  output logic [CNT_W-1:0] tri_count,
  output logic [CNT_W-1:0] pix_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Loop may step only with room for the pixel still in flight plus this step's pixel.
  localparam logic [CW-1:0] ROOM_MAX = CW'(FIFO_DEPTH - 2);

  state_t         state;
  state_t         state_nxt;
  logic           abort_act;
  logic           tri_accept;
  logic           tri_done;
  logic           pix_push;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  pixel_t         push_pix;
  pixel_t         pop_pix;

  assign abort_act  = abort && (state != ST_IDLE);
  assign tri_accept = tri_valid && tri_ready;
  assign pix_push   = ras_write_pixel && !abort_act;
  assign busy       = (state != ST_IDLE);
  assign pix_valid  = !fifo_empty;
  assign push_pix   = '{x: ras_pixel_x, y: ras_pixel_y, depth: ras_pixel_depth,
                        color: ras_pixel_color};

  assign pix_x     = pop_pix.x;
  assign pix_y     = pop_pix.y;
  assign pix_depth = pop_pix.depth;
  assign pix_color = pop_pix.color;

  always_comb begin
    state_nxt               = state;
    tri_ready               = 1'b0;
    tri_done                = 1'b0;
    ras_start_new_triangle  = 1'b0;
    ras_get_boundary_coords = 1'b0;
    ras_form_edges          = 1'b0;
    ras_pixel_loop_setup    = 1'b0;
    ras_rasterize_pixels    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tri_ready = 1'b1;
        if (tri_valid) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        ras_start_new_triangle = 1'b1;
        state_nxt              = ST_BOUND;
      end
      ST_BOUND: begin
        ras_get_boundary_coords = 1'b1;
        state_nxt               = ST_EDGES;
      end
      ST_EDGES: begin
        ras_form_edges = 1'b1;
        state_nxt      = ST_SETUP;
      end
      ST_SETUP: begin
        ras_pixel_loop_setup = 1'b1;
        state_nxt            = ST_RASTER;
      end
      ST_RASTER: begin
        ras_rasterize_pixels = !ras_done && (fifo_count <= ROOM_MAX);
        if (ras_done) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !ras_write_pixel) begin
          tri_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort_act) begin
      state_nxt               = ST_IDLE;
      tri_done                = 1'b0;
      ras_start_new_triangle  = 1'b0;
      ras_get_boundary_coords = 1'b0;
      ras_form_edges          = 1'b0;
      ras_pixel_loop_setup    = 1'b0;
      ras_rasterize_pixels    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ras_v0_x     <= '0;
      ras_v0_y     <= '0;
      ras_v1_x     <= '0;
      ras_v1_y     <= '0;
      ras_v2_x     <= '0;
      ras_v2_y     <= '0;
      ras_v0_depth <= '0;
      ras_v1_depth <= '0;
      ras_v2_depth <= '0;
      ras_color    <= '0;
    end else if (tri_accept) begin
      ras_v0_x     <= tri_v0_x;
      ras_v0_y     <= tri_v0_y;
      ras_v1_x     <= tri_v1_x;
      ras_v1_y     <= tri_v1_y;
      ras_v2_x     <= tri_v2_x;
      ras_v2_y     <= tri_v2_y;
      ras_v0_depth <= tri_v0_depth;
      ras_v1_depth <= tri_v1_depth;
      ras_v2_depth <= tri_v2_depth;
      ras_color    <= tri_color;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tri_count <= '0;
      pix_count <= '0;
    end else begin
      if (tri_done) tri_count <= tri_count + CNT_W'(1);
      if (tri_accept)                          pix_count <= '0;
      else if (pix_push && (pix_count != '1))  pix_count <= pix_count + CNT_W'(1);
    end
  end

  pixel_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .PIXEL_W    (PIXEL_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (abort_act),
    .push  (pix_push),
    .pop   (pix_valid && pix_ready),
    .din   (push_pix),
    .dout  (pop_pix),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_raster_sequencer.sv
// Bench for raster_sequencer: stand-in edge rasterizer, golden pixel scoreboard,
// occupancy model and directed/random triangle scenarios.
module tb_raster_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tri_valid = 1'b0, tri_ready, abort = 1'b0;
  logic [15:0] tri_v0_x = '0, tri_v0_y = '0, tri_v1_x = '0, tri_v1_y = '0, tri_v2_x = '0, tri_v2_y = '0;
  logic [1:0]  tri_v0_depth = '0, tri_v1_depth = '0, tri_v2_depth = '0;
  logic [15:0] tri_color = '0;
  logic ras_start_new_triangle, ras_get_boundary_coords, ras_form_edges, ras_pixel_loop_setup, ras_rasterize_pixels;
  logic [15:0] ras_v0_x, ras_v0_y, ras_v1_x, ras_v1_y, ras_v2_x, ras_v2_y, ras_color;
  logic [1:0]  ras_v0_depth, ras_v1_depth, ras_v2_depth;
  logic ras_write_pixel, ras_done;
  logic [15:0] ras_pixel_x, ras_pixel_y, ras_pixel_color;
  logic [1:0]  ras_pixel_depth;
  logic pix_valid, pix_ready = 1'b0;
  logic [15:0] pix_x, pix_y, pix_color;
  logic [1:0]  pix_depth;
  logic busy;
  logic [CNT_W-1:0] tri_count, pix_count;

  raster_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_v0_x(tri_v0_x), .tri_v0_y(tri_v0_y), .tri_v1_x(tri_v1_x), .tri_v1_y(tri_v1_y),
    .tri_v2_x(tri_v2_x), .tri_v2_y(tri_v2_y), .tri_v0_depth(tri_v0_depth),
    .tri_v1_depth(tri_v1_depth), .tri_v2_depth(tri_v2_depth), .tri_color(tri_color),
    .abort(abort), .ras_start_new_triangle(ras_start_new_triangle),
    .ras_get_boundary_coords(ras_get_boundary_coords), .ras_form_edges(ras_form_edges),
    .ras_pixel_loop_setup(ras_pixel_loop_setup), .ras_rasterize_pixels(ras_rasterize_pixels),
    .ras_v0_x(ras_v0_x), .ras_v0_y(ras_v0_y), .ras_v1_x(ras_v1_x), .ras_v1_y(ras_v1_y),
    .ras_v2_x(ras_v2_x), .ras_v2_y(ras_v2_y), .ras_v0_depth(ras_v0_depth),
    .ras_v1_depth(ras_v1_depth), .ras_v2_depth(ras_v2_depth), .ras_color(ras_color),
    .ras_write_pixel(ras_write_pixel), .ras_done(ras_done), .ras_pixel_x(ras_pixel_x),
    .ras_pixel_y(ras_pixel_y), .ras_pixel_depth(ras_pixel_depth), .ras_pixel_color(ras_pixel_color),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_depth(pix_depth), .pix_color(pix_color), .busy(busy), .tri_count(tri_count),
    .pix_count(pix_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  typedef struct packed {logic [15:0] x; logic [15:0] y; logic [1:0] d; logic [15:0] c;} pix_t;
  pix_t exp_q[$];
  int  exp_tri = 0;
  int  en_cnt  = 0;
  int  occ = 0, occ_nxt = 0;
  bit  rdy_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit inside_tri(int ax, int ay, int bx, int by, int cx, int cy, int px, int py);
    int e0, e1, e2;
    e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
    e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  function automatic int min3(int a, int b, int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Stand-in rasterizer: row-major walk of the bounding box, one registered pixel per enabled step.
  int r_ax, r_ay, r_bx, r_by, r_cx, r_cy, r_minx, r_maxx, r_miny, r_maxy, r_x, r_y;
  logic [1:0]  r_d;
  logic [15:0] r_col;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      ras_write_pixel <= 1'b0;
      ras_done        <= 1'b0;
      ras_pixel_x     <= '0;
      ras_pixel_y     <= '0;
      ras_pixel_depth <= '0;
      ras_pixel_color <= '0;
    end else begin
      ras_write_pixel <= 1'b0;
      if (ras_start_new_triangle) begin
        r_ax <= int'(ras_v0_x); r_ay <= int'(ras_v0_y);
        r_bx <= int'(ras_v1_x); r_by <= int'(ras_v1_y);
        r_cx <= int'(ras_v2_x); r_cy <= int'(ras_v2_y);
        r_d <= ras_v0_depth; r_col <= ras_color;
        ras_done <= 1'b0;
      end
      if (ras_get_boundary_coords) begin
        r_minx <= min3(r_ax, r_bx, r_cx); r_maxx <= max3(r_ax, r_bx, r_cx);
        r_miny <= min3(r_ay, r_by, r_cy); r_maxy <= max3(r_ay, r_by, r_cy);
      end
      if (ras_pixel_loop_setup) begin
        r_x <= r_minx; r_y <= r_miny; ras_done <= 1'b0;
      end
      if (ras_rasterize_pixels) begin
        ras_write_pixel <= inside_tri(r_ax, r_ay, r_bx, r_by, r_cx, r_cy, r_x, r_y);
        ras_pixel_x <= 16'(r_x); ras_pixel_y <= 16'(r_y);
        ras_pixel_depth <= r_d; ras_pixel_color <= r_col;
        if (r_x == r_maxx && r_y == r_maxy) ras_done <= 1'b1;
        else if (r_x == r_maxx) begin r_x <= r_minx; r_y <= r_y + 1; end
        else r_x <= r_x + 1;
      end
    end
  end

  // Scoreboard monitor: a transfer completes at the edge following a valid&&ready sample.
  always @(negedge clock) begin
    if (!reset && pix_valid && pix_ready) begin
      if (exp_q.size() == 0) begin
        check("pix_unexpected", {pix_x, pix_y, pix_depth, pix_color}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        pix_t e;
        e = exp_q.pop_front();
        check("pix_data", {pix_x, pix_y, pix_depth, pix_color}, e);
      end
    end
  end

  // Occupancy model built from the observed push/pop/abort traffic.
  always @(negedge clock) begin
    if (!reset) begin
      bit popn, abn, pushn;
      popn  = pix_valid && pix_ready;
      abn   = abort && busy;
      pushn = ras_write_pixel && !abn;
      check("pix_valid_vs_occ", pix_valid, occ != 0);
      if (ras_rasterize_pixels) begin
        en_cnt++;
        check("enable_needs_room", occ <= FIFO_DEPTH - 2, 1);
      end
      if (pushn) check("no_push_when_full", (occ == FIFO_DEPTH) && !popn, 0);
      occ_nxt = abn ? 0 : occ + int'(pushn) - int'(popn);
      check("occ_bound", occ_nxt <= FIFO_DEPTH, 1);
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin occ = 0; occ_nxt = 0; end
    else occ = occ_nxt;
  end

  always @(posedge clock) begin
    if (rdy_rand) begin
      #1 pix_ready = ($urandom_range(0, 99) < 30);
    end
  end

  task automatic golden_push(input int ax, input int ay, input int bx, input int by, input int cx,
                             input int cy, input logic [1:0] d, input logic [15:0] c,
                             output int cnt, output int area);
    int mnx, mxx, mny, mxy;
    pix_t p;
    mnx = min3(ax, bx, cx); mxx = max3(ax, bx, cx);
    mny = min3(ay, by, cy); mxy = max3(ay, by, cy);
    cnt = 0;
    area = (mxx - mnx + 1) * (mxy - mny + 1);
    for (int y = mny; y <= mxy; y++)
      for (int x = mnx; x <= mxx; x++)
        if (inside_tri(ax, ay, bx, by, cx, cy, x, y)) begin
          p = '{x: 16'(x), y: 16'(y), d: d, c: c};
          exp_q.push_back(p);
          cnt++;
        end
  endtask

  // Waits for IDLE, offers the triangle and returns just after the accept edge (cycle 1).
  task automatic send_tri(input int ax, input int ay, input int bx, input int by, input int cx,
                          input int cy, input logic [1:0] d, input logic [15:0] c,
                          input bit golden, output int cnt, output int area);
    int n = 0;
    @(negedge clock);
    while (!tri_ready && n < 3000) begin @(negedge clock); n++; end
    check("idle_wait_timeout", n < 3000, 1);
    cnt = 0; area = 0;
    if (golden) golden_push(ax, ay, bx, by, cx, cy, d, c, cnt, area);
    @(posedge clock); #1;
    tri_v0_x = 16'(ax); tri_v0_y = 16'(ay); tri_v1_x = 16'(bx); tri_v1_y = 16'(by);
    tri_v2_x = 16'(cx); tri_v2_y = 16'(cy);
    tri_v0_depth = d; tri_v1_depth = d + 2'd1; tri_v2_depth = d + 2'd2; tri_color = c;
    en_cnt = 0;
    tri_valid = 1'b1;
    @(posedge clock); #1;
    tri_valid = 1'b0;
  endtask

  task automatic check_strobes();
    logic [4:0] e;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      e = 5'b10000 >> (k - 1);
      check($sformatf("strobes_cycle%0d", k), {ras_start_new_triangle, ras_get_boundary_coords,
            ras_form_edges, ras_pixel_loop_setup, ras_rasterize_pixels}, e);
    end
  endtask

  task automatic finish_tri(input string tag, input int cnt, input int area);
    int n = 0;
    @(negedge clock);
    while ((busy || exp_q.size() != 0) && n < 5000) begin @(negedge clock); n++; end
    check({tag, "_drain_timeout"}, n < 5000, 1);
    exp_tri++;
    check({tag, "_tri_count"}, tri_count, exp_tri);
    check({tag, "_pix_count"}, pix_count, cnt);
    check({tag, "_loop_steps"}, en_cnt, area);
    check({tag, "_idle_ready"}, {tri_ready, busy, pix_valid}, 3'b100);
  endtask

  initial begin
    int cnt, area, ax, ay, bx, by, cx, cy;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", {tri_ready, busy, pix_valid, ras_start_new_triangle, ras_get_boundary_coords,
          ras_form_edges, ras_pixel_loop_setup, ras_rasterize_pixels}, 8'b1000_0000);
    check("reset_counts", {tri_count, pix_count, ras_v0_x, pix_x}, 64'd0);
    reset = 1'b0;

    // Degenerate single-point triangle.
    pix_ready = 1'b1;
    send_tri(5, 5, 5, 5, 5, 5, 2'd0, 16'hF800, 1'b1, cnt, area);
    check_strobes();
    finish_tri("degenerate", cnt, area);

    // Right triangle, free-flowing output.
    send_tri(0, 0, 8, 0, 0, 8, 2'd1, 16'h07E0, 1'b1, cnt, area);
    check_strobes();
    finish_tri("right_tri", cnt, area);

    // Same triangle with the stream stalled for 40 cycles.
    pix_ready = 1'b0;
    send_tri(0, 0, 8, 0, 0, 8, 2'd1, 16'h07E0, 1'b1, cnt, area);
    repeat (40) @(posedge clock);
    #1 pix_ready = 1'b1;
    finish_tri("stalled", cnt, area);

    // Random triangles under 30% downstream readiness.
    rdy_rand = 1'b1;
    for (int t = 0; t < 6; t++) begin
      ax = $urandom_range(0, 10); ay = $urandom_range(0, 10);
      bx = $urandom_range(0, 10); by = $urandom_range(0, 10);
      cx = $urandom_range(0, 10); cy = $urandom_range(0, 10);
      send_tri(ax, ay, bx, by, cx, cy, 2'($urandom_range(0, 3)), 16'($urandom), 1'b1, cnt, area);
      finish_tri("random", cnt, area);
    end
    rdy_rand = 1'b0;
    @(posedge clock); #2 pix_ready = 1'b0;

    // Abort in the eighth RASTER cycle with the stream stalled.
    send_tri(0, 0, 8, 0, 0, 8, 2'd3, 16'h001F, 1'b0, cnt, area);
    repeat (11) @(posedge clock);
    #1 abort = 1'b1;
    @(negedge clock);
    check("abort_cycle_strobes", {ras_start_new_triangle, ras_get_boundary_coords, ras_form_edges,
          ras_pixel_loop_setup, ras_rasterize_pixels}, 5'b0);
    @(posedge clock); #1 abort = 1'b0;
    @(negedge clock);
    check("after_abort", {pix_valid, busy, tri_ready}, 3'b001);
    check("after_abort_tri_count", tri_count, exp_tri);
    pix_ready = 1'b1;
    send_tri(1, 1, 9, 3, 4, 9, 2'd2, 16'hABCD, 1'b1, cnt, area);
    finish_tri("post_abort", cnt, area);

    // Asynchronous reset between edges during RASTER.
    pix_ready = 1'b0;
    send_tri(0, 0, 8, 0, 0, 8, 2'd1, 16'h1234, 1'b0, cnt, area);
    repeat (6) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_reset_ctrl", {tri_ready, busy, pix_valid, ras_start_new_triangle, ras_get_boundary_coords,
          ras_form_edges, ras_pixel_loop_setup, ras_rasterize_pixels}, 8'b1000_0000);
    check("async_reset_data", {tri_count, pix_count, ras_v1_x, pix_x}, 64'd0);
    check("async_reset_color", {ras_color, pix_color, pix_y}, 48'd0);
    #1 reset = 1'b0;
    exp_tri = 0;
    pix_ready = 1'b1;
    send_tri(2, 7, 10, 2, 6, 10, 2'd0, 16'h5A5A, 1'b1, cnt, area);
    finish_tri("post_reset", cnt, area);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
